// File: rtl/rv32i_load_store_unit_if.sv
// Core-side request/response and data-memory bus bundle for the rv32i load/store unit.
// The slave modport is the load/store unit's view; master is the core/memory side.
interface rv32i_load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        mem_wr_ena;
    logic        mem_rd_ena;
    logic [31:0] mem_rd_data;
    logic        mem_ready;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_rd_data, mem_ready,
        output stall, rsp_valid, rsp_rdata, rsp_error, rsp_cause,
        output mem_addr, mem_wr_data, mem_wr_strb, mem_wr_ena, mem_rd_ena
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_rd_data, mem_ready,
        input  stall, rsp_valid, rsp_rdata, rsp_error, rsp_cause,
        input  mem_addr, mem_wr_data, mem_wr_strb, mem_wr_ena, mem_rd_ena
    );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// rv32i memory-stage load/store unit: turns one core request into one word-aligned
// bus access with byte strobes, extends load data, stalls the pipeline until the
// access completes and reports misaligned / illegal-width / timeout faults.
module rv32i_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    rv32i_load_store_unit_if.slave         bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT3   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t state, state_n;

    // Control registers (reset)
    logic             write_p1;
    logic [CNT_W-1:0] cnt_p1, cnt_n;
    logic             stall_p1;
    logic             err_p2;
    logic [1:0]       cause_p2;

    // Data registers (no reset, qualified by state on the outputs)
    logic [2:0]  f3_p1;
    logic [1:0]  lo_p1;
    logic [31:0] addr_p1;
    logic [3:0]  strb_p1;
    logic [31:0] wdata_p1;
    logic [31:0] rdata_p2;

    // Combinational control
    logic       stall_c;
    logic       rd_c;
    logic       wr_c;
    logic       rv_c;
    logic       accept;
    logic       capture;
    logic       fault_set;
    logic [1:0] cause_n;

    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !write;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strb(input logic write, input logic [2:0] f3,
                                              input logic [1:0] lo);
        logic [3:0] s;
        if (!write) begin
            s = 4'b0000;
        end else begin
            case (f3[1:0])
                2'b00:   s = 4'b0001 << lo;
                2'b01:   s = lo[1] ? 4'b1100 : 4'b0011;
                default: s = 4'b1111;
            endcase
        end
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic write, input logic [2:0] f3,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        if (!write) begin
            d = 32'h0;
        end else begin
            case (f3[1:0])
                2'b00:   d = {4{wdata[7:0]}};
                2'b01:   d = {2{wdata[15:0]}};
                default: d = wdata;
            endcase
        end
        return d;
    endfunction

    // Byte/half lane select followed by sign or zero extension; funct3[2] marks unsigned.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic [31:0]        r;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h   = lo[1] ? word[31:16] : word[15:0];
        b_s = signed'(b);
        h_s = signed'(h);
        case (f3)
            3'b000:  r = 32'(b_s);
            3'b001:  r = 32'(h_s);
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // FSM next-state, handshake outputs and register load strobes
    always_comb begin
        state_n   = state;
        cnt_n     = cnt_p1;
        stall_c   = 1'b0;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        rv_c      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        fault_set = 1'b0;
        cause_n   = CAUSE_NONE;
        case (state)
            IDLE: begin
                stall_c = bus.req_valid;
                if (bus.req_valid) begin
                    if (!f3_legal(bus.req_write, bus.req_funct3)) begin
                        fault_set = 1'b1;
                        cause_n   = CAUSE_FUNCT3;
                        state_n   = RESP;
                    end else if (is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                        fault_set = 1'b1;
                        cause_n   = CAUSE_MISALIGN;
                        state_n   = RESP;
                    end else begin
                        accept  = 1'b1;
                        cnt_n   = '0;
                        state_n = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                rd_c    = !write_p1;
                wr_c    = write_p1;
                if (bus.mem_ready) begin
                    capture = 1'b1;
                    state_n = RESP;
                end else if (cnt_p1 == CNT_LAST) begin
                    fault_set = 1'b1;
                    cause_n   = CAUSE_TIMEOUT;
                    state_n   = RESP;
                end else begin
                    cnt_n = cnt_p1 + CNT_W'(1);
                end
            end
            RESP: begin
                rv_c    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Frozen: nothing advances, bus quiet, stall keeps last cycle's value
        if (!ena) begin
            state_n   = state;
            cnt_n     = cnt_p1;
            stall_c   = stall_p1;
            rd_c      = 1'b0;
            wr_c      = 1'b0;
            rv_c      = 1'b0;
            accept    = 1'b0;
            capture   = 1'b0;
            fault_set = 1'b0;
        end
        if (!rst) begin
            stall_c = 1'b0;
            rd_c    = 1'b0;
            wr_c    = 1'b0;
            rv_c    = 1'b0;
        end
    end

    // Control state: FSM, timeout counter, held stall, response status
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt_p1   <= '0;
            stall_p1 <= 1'b0;
            write_p1 <= 1'b0;
            err_p2   <= 1'b0;
            cause_p2 <= CAUSE_NONE;
        end else begin
            state    <= state_n;
            cnt_p1   <= cnt_n;
            stall_p1 <= stall_c;
            if (accept) begin
                write_p1 <= bus.req_write;
            end
            if (fault_set || capture) begin
                err_p2   <= fault_set;
                cause_p2 <= cause_n;
            end
        end
    end

    // Request latch on accept; load result capture on memory completion
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_p1    <= bus.req_funct3;
            lo_p1    <= bus.req_addr[1:0];
            addr_p1  <= {bus.req_addr[31:2], 2'b00};
            strb_p1  <= store_strb(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
            wdata_p1 <= store_data(bus.req_write, bus.req_funct3, bus.req_wdata);
        end
        if (capture) begin
            rdata_p2 <= write_p1 ? 32'h0 : load_extend(f3_p1, lo_p1, bus.mem_rd_data);
        end
    end

    assign bus.stall       = stall_c;
    assign bus.mem_rd_ena  = rd_c;
    assign bus.mem_wr_ena  = wr_c;
    assign bus.mem_addr    = (rst && state == ACCESS) ? addr_p1  : 32'h0;
    assign bus.mem_wr_data = (rst && state == ACCESS) ? wdata_p1 : 32'h0;
    assign bus.mem_wr_strb = (rst && state == ACCESS) ? strb_p1  : 4'b0000;
    assign bus.rsp_valid   = rv_c;
    assign bus.rsp_error   = rv_c && err_p2;
    assign bus.rsp_cause   = rv_c ? cause_p2 : CAUSE_NONE;
    assign bus.rsp_rdata   = (rv_c && !err_p2) ? rdata_p2 : 32'h0;

endmodule

// File: doc/rv32i_load_store_unit.md
Name: rv32i_load_store_unit

Overview:
- Memory-stage load/store unit between the pipelined rv32i core's memory stage and a variable-latency data memory with a ready handshake.
- Converts each core request into a single word-aligned bus transaction with byte strobes.
- Performs RV32I load extraction and sign/zero extension.
- Stalls the pipeline until the access completes, and reports misaligned, illegal-width and timeout faults.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS without mem_ready before a timeout fault; must be >= 1.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous active-low reset
- ena  input  1  global enable; 0 freezes all state
- req_valid  input  1  memory-stage request present
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign field
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data, unshifted, low-aligned
- stall  output  1  hold fetch/decode/execute/memory stages
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  extended load result; 0 for stores and faults
- rsp_error  output  1  completion is a fault
- rsp_cause  output  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
- mem_addr  output  32  word address ({req_addr[31:2],2'b00})
- mem_wr_data  output  32  lane-replicated store data
- mem_wr_strb  output  4  byte-lane enables
- mem_wr_ena  output  1  write request
- mem_rd_ena  output  1  read request
- mem_rd_data  input  32  read word; valid when mem_ready=1
- mem_ready  input  1  memory completes the current request this cycle

Behaviour:
- Reset (rst=0 at edge): state IDLE, timeout counter 0; all outputs 0 from the next cycle. Reset during ACCESS aborts the access: strobes drop and there is no response.
- ena=0: state, counter and latched request held. mem_rd_ena and mem_wr_ena forced 0, mem_ready ignored, rsp_valid forced 0, stall holds its current value.
- States: IDLE, ACCESS, RESP.
- IDLE, no request (req_valid=0): stall=0, no bus activity.
- IDLE accept (ena=1, req_valid=1):
  - Legal funct3 is load 000/001/010/100/101 and store 000/001/010.
  - Illegal funct3 -> RESP with cause 10.
  - Otherwise misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) -> RESP with cause 01.
  - Otherwise latch the word address, strobes, write data, funct3 and addr[1:0]; counter=0; -> ACCESS.
  - stall=1 combinationally in the accepting cycle whenever req_valid=1.
- ACCESS:
  - stall=1; mem_rd_ena=!write, mem_wr_ena=write.
  - mem_addr, mem_wr_data and mem_wr_strb held constant.
  - mem_ready=1 -> capture and extend mem_rd_data, -> RESP, no error.
  - Otherwise counter++; counter reaching TIMEOUT_CYCLES-1 without ready -> RESP with cause 11, rdata 0.
  - The request is issued exactly once per access.
- RESP: rsp_valid=1 for exactly one cycle, stall=0 (pipeline advances), -> IDLE. A req_valid seen in RESP is not accepted; it is accepted from IDLE on the following cycle.
- Store strobes and data:
  - SB: strb = 0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - SH: strb = 0011<<(2*addr[1]), data = {2{wdata[15:0]}}.
  - SW: strb = 1111, data = wdata.
  - Loads: strb = 0000.
- Load extraction:
  - LB/LBU take byte lane addr[1:0]; LH/LHU take half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Faults never touch the bus. rsp_rdata=0 whenever rsp_error=1.
- Latency: an aligned access with mem_ready in the first ACCESS cycle gives stall high for 2 cycles (accept, ACCESS) and the response in the 3rd cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=1 -> all outputs 0, no mem_rd_ena/mem_wr_ena.
- LB at addr 0x103, mem_rd_data=0x80FF_1234, ready on the first ACCESS cycle:
  - mem_addr=0x100, mem_rd_ena pulses 1 cycle.
  - rsp_valid with rsp_rdata=0xFFFF_FF80.
  - Same access as LBU -> rsp_rdata=0x0000_0080.
- SH at addr 0x202, wdata=0xDEAD_BEEF, ready after 3 wait cycles:
  - mem_addr=0x200, mem_wr_strb=1100, mem_wr_data=0xBEEF_BEEF held for 4 ACCESS cycles.
  - stall high for 5 cycles total, then one rsp_valid with rsp_rdata=0.
- LW at addr 0x301 -> rsp_error=1, rsp_cause=01, no bus strobe. funct3=011 load at addr 0x300 -> rsp_cause=10.
- Timeout: SW to 0x400 with mem_ready stuck at 0, TIMEOUT_CYCLES=4 -> exactly 4 ACCESS cycles, then rsp_error=1, rsp_cause=11.
- ena=0 for 2 cycles mid-ACCESS with mem_ready=1 in those cycles -> ready ignored, strobes low, state held. Completion occurs on the first ena=1 cycle with ready; rst=0 in ACCESS -> no rsp_valid and the unit is in IDLE afterwards.
